// File: rtl/rv_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Both requesters use a single request record type: destination register and data.
package rv_wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // x0 never produces a pending bit.
  function automatic logic [XLEN-1:0] onehot32(input logic [REG_ADDR_W-1:0] rd);
    logic [XLEN-1:0] oh;
    oh = '0;
    if (rd != '0) oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests. Every entry's valid bit and rd are
// visible so the owner can build a pending-write mask.
module wb_fifo
  import rv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  wb_req_t                             push_req,
  input  logic                                pop,
  output wb_req_t                             head,
  output logic                                full,
  output logic                                empty,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]             wptr_q, wptr_d;
  logic [AW:0]             rptr_q, rptr_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  wb_req_t [DEPTH-1:0]     mem_q;
  logic [AW-1:0]           widx, ridx;
  logic                    do_push, do_pop;

  assign widx  = wptr_q[AW-1:0];
  assign ridx  = rptr_q[AW-1:0];
  assign empty = (wptr_q == rptr_q);
  // Same slot, opposite lap: the writer has wrapped once more than the reader.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (widx == ridx);

  // A push while full is refused even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    valid_d = valid_q;
    if (do_pop)  valid_d[ridx] = 1'b0;
    if (do_push) valid_d[widx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= '0;
      mem_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      if (do_push) mem_q[widx] <= push_req;
    end
  end

  assign head      = mem_q[ridx];
  assign ent_valid = valid_q;

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_rd[i] = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the pipeline writeback (priority) and a
// buffered long-latency return path, with a starvation guard and a pending-write mask.
module regfile_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic [REG_ADDR_W-1:0] p_rd,
  input  logic [XLEN-1:0]       p_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [REG_ADDR_W-1:0] s_rd,
  input  logic [XLEN-1:0]       s_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]       rf_wd3,
  output logic [XLEN-1:0]       pend_mask
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] StarveMax = CW'(STARVE_MAX);

  wb_req_t                          s_req, head, win_req;
  logic                             fifo_full, fifo_empty;
  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
  logic                             force_head, grant_p, grant_s, grant;
  logic [CW-1:0]                    starve_q, starve_d;
  logic                             rf_we_q;
  logic [REG_ADDR_W-1:0]            rf_a3_q;
  logic [XLEN-1:0]                  rf_wd3_q;

  assign s_req = '{rd: s_rd, data: s_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s_valid),
    .push_req  (s_req),
    .pop       (grant_s),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  assign force_head = (starve_q == StarveMax) && !fifo_empty;
  assign grant_p    = p_valid && !force_head;
  // A push into an empty FIFO is only visible as head from the next cycle.
  assign grant_s    = !grant_p && !fifo_empty;
  assign grant      = grant_p || grant_s;
  assign win_req    = grant_p ? '{rd: p_rd, data: p_data} : head;

  assign p_ready = !force_head;
  assign s_ready = !fifo_full;

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || grant_s) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd3_q <= '0;
    end else begin
      starve_q <= starve_d;
      rf_we_q  <= grant && (win_req.rd != '0);
      if (grant) begin
        rf_a3_q  <= win_req.rd;
        rf_wd3_q <= win_req.data;
      end
    end
  end

  assign rf_we  = rf_we_q;
  assign rf_a3  = rf_a3_q;
  assign rf_wd3 = rf_wd3_q;

  // Built from registered state only, so the hazard unit sees no path from the requesters.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_valid[i]) pend_mask = pend_mask | onehot32(ent_rd[i]);
    end
    if (rf_we_q) pend_mask = pend_mask | onehot32(rf_a3_q);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, corner-case sequences
// and a randomized phase, all checked against a transaction-level reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk, rst_n;
  logic        p_valid, p_ready, s_valid, s_ready;
  logic [4:0]  p_rd, s_rd, rf_a3;
  logic [31:0] p_data, s_data, rf_wd3, pend_mask;
  logic        rf_we;

  regfile_wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .p_rd      (p_rd),
    .p_data    (p_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_rd      (s_rd),
    .s_data    (s_data),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } req_t;
  typedef struct { logic we; logic [4:0] a3; logic [31:0] wd3; } out_t;
  typedef struct {
    logic pv; logic [4:0] prd; logic [31:0] pd;
    logic sv; logic [4:0] srd; logic [31:0] sd;
    logic e_pready; logic e_sready;
    logic e_we; logic [4:0] e_a3; logic [31:0] e_wd3; logic [31:0] e_pend;
  } vec_t;

  req_t        m_q[$];
  out_t        sb[$];
  int          m_cnt;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  int          n_checks, n_errors;
  logic        pre_pready, pre_sready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] r;
    r = '0;
    foreach (m_q[i]) if (m_q[i].rd != 5'd0) r[m_q[i].rd] = 1'b1;
    if (m_we && m_a3 != 5'd0) r[m_a3] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    m_cnt = 0;
    m_we  = 1'b0;
    m_a3  = '0;
    m_wd3 = '0;
  endtask

  // One clock: drive, check readies, advance the model, then check the registered outputs.
  task automatic apply(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic sv, input logic [4:0] srd, input logic [31:0] sd);
    logic force_h, gp, gs, psh, was_empty;
    req_t hd;
    out_t o;
    p_valid = pv; p_rd = prd; p_data = pd;
    s_valid = sv; s_rd = srd; s_data = sd;
    #1;
    pre_pready = p_ready;
    pre_sready = s_ready;
    force_h = (m_cnt == STARVE_MAX) && (m_q.size() != 0);
    chk("p_ready", 32'(p_ready), 32'(!force_h));
    chk("s_ready", 32'(s_ready), 32'(m_q.size() < DEPTH));
    gp        = pv && !force_h;
    gs        = !gp && (m_q.size() != 0);
    psh       = sv && (m_q.size() < DEPTH);
    was_empty = (m_q.size() == 0);
    if (gp) begin
      m_we = (prd != 5'd0); m_a3 = prd; m_wd3 = pd;
    end else if (gs) begin
      hd = m_q.pop_front();
      m_we = (hd.rd != 5'd0); m_a3 = hd.rd; m_wd3 = hd.data;
    end else begin
      m_we = 1'b0;
    end
    if (was_empty || gs) m_cnt = 0;
    else if (m_cnt < STARVE_MAX) m_cnt++;
    if (psh) m_q.push_back('{rd: srd, data: sd});
    sb.push_back('{we: m_we, a3: m_a3, wd3: m_wd3});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      o = sb.pop_front();
      chk("rf_we", 32'(rf_we), 32'(o.we));
      chk("rf_a3", 32'(rf_a3), 32'(o.a3));
      chk("rf_wd3", rf_wd3, o.wd3);
    end
    chk("pend_mask", pend_mask, model_pend());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    // Single-cycle primary write, then secondary fill-to-full behind x0 primaries, then x0 on s.
    vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,    1, 1, 1, 5, 32'hDEADBEEF, 32'h0000_0020};
    vecs[1] = '{0, 0, 0,            0, 0, 0,    1, 1, 0, 5, 32'hDEADBEEF, 32'h0000_0000};
    vecs[2] = '{1, 0, 0,            1, 3, 32'h11, 1, 1, 0, 0, 32'h0,      32'h0000_0008};
    vecs[3] = '{1, 0, 0,            1, 4, 32'h22, 1, 1, 0, 0, 32'h0,      32'h0000_0018};
    vecs[4] = '{0, 0, 0,            0, 0, 0,    1, 0, 1, 3, 32'h11,       32'h0000_0018};
    vecs[5] = '{0, 0, 0,            0, 0, 0,    1, 1, 1, 4, 32'h22,       32'h0000_0010};
    vecs[6] = '{0, 0, 0,            0, 0, 0,    1, 1, 0, 4, 32'h22,       32'h0000_0000};
    vecs[7] = '{0, 0, 0,            1, 0, 32'h55, 1, 1, 0, 4, 32'h22,     32'h0000_0000};
    vecs[8] = '{0, 0, 0,            0, 0, 0,    1, 1, 0, 0, 32'h55,       32'h0000_0000};
    vecs[9] = '{0, 0, 0,            0, 0, 0,    1, 1, 0, 0, 32'h55,       32'h0000_0000};

    rst_n = 1'b0;
    p_valid = 0; p_rd = 0; p_data = 0;
    s_valid = 0; s_rd = 0; s_data = 0;
    model_reset();
    #12;
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_rf_a3", 32'(rf_a3), 32'd0);
    chk("reset_rf_wd3", rf_wd3, 32'd0);
    chk("reset_pend", pend_mask, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_s_ready", 32'(s_ready), 32'd1);
    chk("post_reset_p_ready", 32'(p_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].pv, vecs[i].prd, vecs[i].pd, vecs[i].sv, vecs[i].srd, vecs[i].sd);
      chk($sformatf("vec%0d_p_ready", i), 32'(pre_pready), 32'(vecs[i].e_pready));
      chk($sformatf("vec%0d_s_ready", i), 32'(pre_sready), 32'(vecs[i].e_sready));
      chk($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d_rf_a3", i), 32'(rf_a3), 32'(vecs[i].e_a3));
      chk($sformatf("vec%0d_rf_wd3", i), rf_wd3, vecs[i].e_wd3);
      chk($sformatf("vec%0d_pend", i), pend_mask, vecs[i].e_pend);
    end

    // Starvation: primary streams; the queued entry is forced after exactly STARVE_MAX losses.
    for (int rep = 0; rep < 2; rep++) begin
      apply(1'b1, 5'd9, 32'h100, 1'b1, 5'd7, 32'h77 + rep);
      for (int k = 0; k <= STARVE_MAX + 1; k++) begin
        apply(1'b1, 5'd9, 32'h200 + k, 1'b0, 5'd0, 32'd0);
        chk($sformatf("starve%0d_p_ready_k%0d", rep, k), 32'(pre_pready),
            32'(k != STARVE_MAX));
        if (k == STARVE_MAX) begin
          chk($sformatf("starve%0d_forced_a3", rep), 32'(rf_a3), 32'd7);
          chk($sformatf("starve%0d_forced_wd3", rep), rf_wd3, 32'h77 + rep);
        end
        if (k == STARVE_MAX + 1) chk($sformatf("starve%0d_resume", rep), rf_wd3, 32'h200 + k);
      end
    end
    idle(2);

    // Push and pop in the same cycle at occupancy one.
    apply(1'b1, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0);
    apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB1);
    chk("pp_first_a3", 32'(rf_a3), 32'd10);
    chk("pp_pend", pend_mask, 32'h0000_0C00);
    apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("pp_second_a3", 32'(rf_a3), 32'd11);
    chk("pp_second_wd3", rf_wd3, 32'hB1);
    idle(2);

    // Asynchronous reset mid-cycle with a full FIFO and a live output write.
    apply(1'b1, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    apply(1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h44);
    chk("pre_reset_pend", pend_mask, 32'h0000_0058);
    p_valid = 0; s_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rf_we", 32'(rf_we), 32'd0);
    chk("async_reset_pend", pend_mask, 32'd0);
    chk("async_reset_rf_a3", 32'(rf_a3), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_s_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk($sformatf("no_stale_write%0d", i), 32'(rf_we), 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
